// File: rtl/serializer_pattern_sequencer.sv
// Pattern RAM sequencer for an SN65LV1023 serializer: loads a burst of
// pattern words into an external RAM, holds SYNC for a lock period, then
// replays the stored pattern onto the 10-bit parallel bus once or looped.
module serializer_pattern_sequencer #(
  parameter int unsigned           ADDR_WIDTH  = 11,
  parameter int unsigned           DATA_WIDTH  = 10,
  parameter int unsigned           SYNC_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = '0
) (
  input  logic                  clock,
  input  logic                  reset_active_low,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  input  logic                  play_start,
  input  logic                  play_loop,
  input  logic                  play_stop,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [DATA_WIDTH-1:0] data_bus,
  output logic                  data_valid,
  output logic                  sync,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   loaded_words
);

  localparam int unsigned SYNC_W = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SYNC  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ONE_A     = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_W     = 1;
  localparam logic [SYNC_W-1:0]     SYNC_ONE  = 1;
  localparam logic [SYNC_W-1:0]     SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [SYNC_W-1:0]     sync_cnt;
  logic                  loop_mode;
  logic                  rd_pending;
  logic                  load_accept;
  logic                  load_end;
  logic                  raddr_last;

  // Load beat acceptance, end-of-burst and end-of-pattern detection.
  always_comb begin
    load_accept = (state == S_LOAD) && load_valid;
    load_end    = load_accept && (load_last || (waddr == '1));
    raddr_last  = ({1'b0, raddr} == (loaded_words - ONE_W));
  end

  // Combinational port views of the state and address counters.
  always_comb begin
    load_ready = (state == S_LOAD);
    ram_we     = load_accept;
    ram_waddr  = waddr;
    ram_wdata  = load_accept ? load_data : '0;
    ram_raddr  = raddr;
    sync       = (state == S_SYNC);
    busy       = (state != S_IDLE);
  end

  // Control FSM with write/read address counters and sync timer.
  always_ff @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      state        <= S_IDLE;
      waddr        <= '0;
      raddr        <= '0;
      sync_cnt     <= '0;
      loop_mode    <= 1'b0;
      loaded_words <= '0;
      load_done    <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state <= S_LOAD;
            waddr <= '0;
          end else if (play_start && (loaded_words != '0)) begin
            state     <= S_SYNC;
            loop_mode <= play_loop;
            sync_cnt  <= '0;
            raddr     <= '0;
          end
        end
        S_LOAD: begin
          if (play_stop) begin
            state        <= S_IDLE;
            loaded_words <= '0;
          end else if (load_accept) begin
            waddr <= waddr + ONE_A;
            if (load_end) begin
              loaded_words <= {1'b0, waddr} + ONE_W;
              load_done    <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end
        S_SYNC: begin
          if (play_stop) begin
            state <= S_IDLE;
          end else if (sync_cnt == SYNC_LAST) begin
            state <= S_PLAY;
          end else begin
            sync_cnt <= sync_cnt + SYNC_ONE;
          end
        end
        S_PLAY: begin
          if (play_stop) begin
            state <= S_DRAIN;
          end else if (raddr_last) begin
            if (loop_mode) raddr <= '0;
            else           state <= S_DRAIN;
          end else begin
            raddr <= raddr + ONE_A;
          end
        end
        S_DRAIN: begin
          // Leave only once the last read issued in PLAY has reached data_bus.
          if (!rd_pending) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output pipeline: a read issued in PLAY lands on data_bus one cycle later.
  always_ff @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      rd_pending <= 1'b0;
      data_bus   <= IDLE_WORD;
      data_valid <= 1'b0;
    end else begin
      rd_pending <= (state == S_PLAY);
      if (rd_pending) begin
        data_bus   <= ram_rdata;
        data_valid <= 1'b1;
      end else begin
        data_bus   <= IDLE_WORD;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serializer_pattern_sequencer.sv
// Self-checking bench for serializer_pattern_sequencer: directed scenarios
// followed by randomized command traffic, all checked every cycle against a
// timeline-based behavioural model.
module tb_serializer_pattern_sequencer;

  localparam int AW    = 11;
  localparam int DW    = 10;
  localparam int S     = 8;
  localparam int DEPTH = 2048;
  localparam int BIG   = 1 << 30;
  localparam logic [DW-1:0] IDLE_W = 10'h2A5;

  logic          clock;
  logic          reset_active_low;
  logic          load_start, load_valid, load_last;
  logic [DW-1:0] load_data;
  logic          load_ready, load_done;
  logic          play_start, play_loop, play_stop;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we;
  logic [DW-1:0] data_bus;
  logic          data_valid, sync, busy;
  logic [AW:0]   loaded_words;

  serializer_pattern_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SYNC_CYCLES(S),
    .IDLE_WORD  (IDLE_W)
  ) dut (
    .clock           (clock),
    .reset_active_low(reset_active_low),
    .load_start      (load_start),
    .load_valid      (load_valid),
    .load_last       (load_last),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .load_done       (load_done),
    .play_start      (play_start),
    .play_loop       (play_loop),
    .play_stop       (play_stop),
    .ram_waddr       (ram_waddr),
    .ram_wdata       (ram_wdata),
    .ram_we          (ram_we),
    .ram_raddr       (ram_raddr),
    .ram_rdata       (ram_rdata),
    .data_bus        (data_bus),
    .data_valid      (data_valid),
    .sync            (sync),
    .busy            (busy),
    .loaded_words    (loaded_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pattern RAM: registered read, write-first.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= (ram_we && ram_waddr == ram_raddr) ? ram_wdata : mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. A play session is tracked as t = edges since the
  // play_start edge: sync for t<S, read j issued at t=S+j, word j shown at
  // t=S+2+j, session over at t=S+3+j_last.
  int            m_mode = 0;   // 0 idle, 1 loading, 2 play session
  int            m_t = 0, m_jl = 0, m_n = 0, m_widx = 0, m_loaded = 0;
  bit            m_done = 0;
  logic [DW-1:0] m_pat [DEPTH];

  always @(posedge clock or negedge reset_active_low) begin
    if (!reset_active_low) begin
      m_mode = 0; m_loaded = 0; m_widx = 0; m_done = 0; m_t = 0;
    end else begin
      m_done = 0;
      if (m_mode == 0) begin
        if (load_start) begin
          m_mode = 1; m_widx = 0;
        end else if (play_start && m_loaded != 0) begin
          m_mode = 2; m_t = 0; m_n = m_loaded;
          m_jl = play_loop ? BIG : m_loaded - 1;
        end
      end else if (m_mode == 1) begin
        if (play_stop) begin
          m_mode = 0; m_loaded = 0;
        end else if (load_valid) begin
          m_pat[m_widx] = load_data;
          m_widx++;
          if (load_last || m_widx == DEPTH) begin
            m_loaded = m_widx; m_done = 1; m_mode = 0;
          end
        end
      end else begin
        m_t++;
        if (play_stop) begin
          if (m_t <= S) m_mode = 0;
          else if (m_t - 1 - S <= m_jl) m_jl = m_t - 1 - S;
        end
        if (m_mode == 2 && m_t >= S + 3 + m_jl) m_mode = 0;
      end
    end
  end

  int            cyc = 0;
  always @(posedge clock) cyc++;

  logic [DW-1:0] seen[$];
  int            sync_seen = 0, done_seen = 0, first_cyc = -1;

  // Per-cycle comparison against the model, plus stream capture for directed checks.
  always @(negedge clock) begin
    int            k;
    bit            ev;
    logic [DW-1:0] eb;
    k  = m_t - S - 2;
    ev = (m_mode == 2) && (k >= 0) && (k <= m_jl);
    eb = IDLE_W;
    if (ev) eb = m_pat[k % m_n];
    chk("busy",         32'(busy),         32'(m_mode != 0));
    chk("load_ready",   32'(load_ready),   32'(m_mode == 1));
    chk("load_done",    32'(load_done),    32'(m_done));
    chk("loaded_words", 32'(loaded_words), 32'(m_loaded));
    chk("sync",         32'(sync),         32'(m_mode == 2 && m_t < S));
    chk("data_valid",   32'(data_valid),   32'(ev));
    chk("data_bus",     32'(data_bus),     32'(eb));
    chk("ram_we",       32'(ram_we),       32'(m_mode == 1 && load_valid));
    if (m_mode == 1 && load_valid) begin
      chk("ram_waddr", 32'(ram_waddr), 32'(m_widx));
      chk("ram_wdata", 32'(ram_wdata), 32'(load_data));
    end
    if (data_valid) begin
      seen.push_back(data_bus);
      if (first_cyc < 0) first_cyc = cyc;
    end
    if (sync) sync_seen++;
    if (load_done) done_seen++;
  end

  logic [DW-1:0] stim [DEPTH+1];
  int            c0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_mon();
    seen.delete();
    sync_seen = 0; done_seen = 0; first_cyc = -1;
  endtask

  task automatic load_words(input int n, input bit use_last);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = stim[i];
      load_last  = use_last && (i == n - 1);
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    step();
    step();
  endtask

  task automatic play(input bit lp);
    play_start = 1'b1;
    play_loop  = lp;
    c0 = cyc + 1;
    step();
    play_start = 1'b0;
    play_loop  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int i;
    i = 0;
    while (busy && i < budget) begin
      step();
      i++;
    end
    chk(nm, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_active_low = 1'b0;
    load_start = 0; load_valid = 0; load_last = 0; load_data = '0;
    play_start = 0; play_loop = 0; play_stop = 0;
    step();
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_bus",    32'(data_bus),     32'h2A5);
    chk("rst_loaded", 32'(loaded_words), 32'd0);
    step();
    reset_active_low = 1'b1;
    step();

    // 1: four-word load, one-shot play
    stim[0] = 10'h001; stim[1] = 10'h002; stim[2] = 10'h003; stim[3] = 10'h3FF;
    clr_mon();
    load_words(4, 1'b1);
    chk("t1_loaded", 32'(loaded_words), 32'd4);
    chk("t1_done_pulses", 32'(done_seen), 32'd1);
    clr_mon();
    play(1'b0);
    wait_idle(40, "t1_idle");
    chk("t1_sync_cycles", 32'(sync_seen), 32'd8);
    chk("t1_first_latency", 32'(first_cyc - c0), 32'd10);
    chk("t1_nwords", 32'(seen.size()), 32'd4);
    if (seen.size() == 4) begin
      chk("t1_w0", 32'(seen[0]), 32'h001);
      chk("t1_w1", 32'(seen[1]), 32'h002);
      chk("t1_w2", 32'(seen[2]), 32'h003);
      chk("t1_w3", 32'(seen[3]), 32'h3FF);
    end
    chk("t1_bus_idle", 32'(data_bus), 32'h2A5);

    // 2: full-depth load, extra beat must not be written
    for (int i = 0; i <= DEPTH; i++) stim[i] = 10'($urandom);
    stim[DEPTH] = ~stim[0];
    clr_mon();
    load_words(DEPTH + 1, 1'b0);
    chk("t2_loaded", 32'(loaded_words), 32'd2048);
    chk("t2_done_pulses", 32'(done_seen), 32'd1);
    chk("t2_mem0", 32'(mem[0]), 32'(stim[0]));
    chk("t2_mem_last", 32'(mem[DEPTH-1]), 32'(stim[DEPTH-1]));

    // 3: looped 3-word play, stop while the second C is read
    for (int i = 0; i < 3; i++) stim[i] = 10'($urandom);
    load_words(3, 1'b1);
    clr_mon();
    play(1'b1);
    repeat (S + 5) step();
    chk("t3_raddr_at_stop", 32'(ram_raddr), 32'd2);
    play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    wait_idle(3, "t3_idle");
    chk("t3_nwords", 32'(seen.size()), 32'd6);
    if (seen.size() == 6)
      for (int i = 0; i < 6; i++) chk("t3_word", 32'(seen[i]), 32'(stim[i % 3]));

    // 4: load wins over play; play_start during LOAD ignored
    load_start = 1'b1; play_start = 1'b1;
    step();
    load_start = 1'b0; play_start = 1'b0;
    chk("t4_load_wins", 32'(load_ready), 32'd1);
    chk("t4_no_sync", 32'(sync), 32'd0);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk("t4_play_in_load", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 10'h155; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    step();
    chk("t4_loaded", 32'(loaded_words), 32'd1);

    // 5a: stop mid-load, then play with nothing loaded
    clr_mon();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 10'h0AA;
    step();
    step();
    load_valid = 1'b0; play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    step();
    chk("t5_loaded_cleared", 32'(loaded_words), 32'd0);
    chk("t5_no_done", 32'(done_seen), 32'd0);
    play(1'b0);
    chk("t5_play_empty", 32'(busy), 32'd0);
    step();

    // 5b: stop during sync
    for (int i = 0; i < 3; i++) stim[i] = 10'($urandom);
    load_words(3, 1'b1);
    clr_mon();
    play(1'b0);
    repeat (3) step();
    play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    chk("t5_sync_dropped", 32'(sync), 32'd0);
    repeat (4) step();
    chk("t5_no_valid", 32'(seen.size()), 32'd0);

    // 6: asynchronous reset mid-play
    for (int i = 0; i < 4; i++) stim[i] = 10'($urandom);
    load_words(4, 1'b1);
    play(1'b0);
    repeat (S + 3) step();
    #2 reset_active_low = 1'b0;
    #1;
    chk("t6_busy",    32'(busy),         32'd0);
    chk("t6_sync",    32'(sync),         32'd0);
    chk("t6_valid",   32'(data_valid),   32'd0);
    chk("t6_bus",     32'(data_bus),     32'h2A5);
    chk("t6_loaded",  32'(loaded_words), 32'd0);
    chk("t6_raddr",   32'(ram_raddr),    32'd0);
    @(negedge clock);
    #2 reset_active_low = 1'b1;
    step();
    play(1'b0);
    chk("t6_play_after_reset", 32'(busy), 32'd0);
    step();

    // Randomized command traffic
    repeat (3000) begin
      load_start = ($urandom % 16) == 0;
      play_start = ($urandom % 12) == 0;
      play_loop  = 1'($urandom);
      load_valid = 1'($urandom);
      load_last  = ($urandom % 6) == 0;
      load_data  = 10'($urandom);
      play_stop  = ($urandom % 30) == 0;
      step();
    end
    load_start = 0; play_start = 0; load_valid = 0; load_last = 0; play_loop = 0;
    play_stop = 1'b1;
    step();
    play_stop = 1'b0;
    wait_idle(10, "rand_final_idle");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializer_pattern_sequencer.md
Name: serializer_pattern_sequencer

Overview:
Single-clock controller that owns a pattern RAM feeding the 10-bit parallel bus of an SN65LV1023 serializer.
- Accepts a burst of pattern words from a loader through a valid/ready handshake and writes them into the RAM.
- Asserts the serializer SYNC request for a fixed lock period, then plays the stored pattern onto the data bus, either once or looped.
- Sits between the PRBS/pattern source and the serializer pins, replacing free-running address counters with an explicit sequenced state machine.

Parameters:
ADDR_WIDTH, 11, RAM address width; pattern depth is 2**ADDR_WIDTH words.
DATA_WIDTH, 10, pattern word width; equals the serializer parallel bus width.
SYNC_CYCLES, 1024, number of cycles sync is held high before playback (at least 1).
IDLE_WORD, 0, value driven on data_bus whenever no valid pattern word is present.

Ports:
clock  input  1  single clock for all logic and both RAM ports.
reset_active_low  input  1  asynchronous, active-low reset.
load_start  input  1  one-cycle pulse; begin a load (honoured in IDLE only).
load_valid  input  1  loader word valid.
load_last  input  1  qualifies the final word of the burst.
load_data  input  DATA_WIDTH  loader word.
load_ready  output  1  high in LOAD.
load_done  output  1  one-cycle pulse when LOAD completes.
play_start  input  1  one-cycle pulse; begin sync and playback (honoured in IDLE only).
play_loop  input  1  sampled with play_start; 1 = repeat the pattern forever.
play_stop  input  1  abort LOAD or PLAY.
ram_waddr  output  ADDR_WIDTH  RAM write address.
ram_wdata  output  DATA_WIDTH  RAM write data.
ram_we  output  1  RAM write enable.
ram_raddr  output  ADDR_WIDTH  RAM read address.
ram_rdata  input  DATA_WIDTH  RAM read data; registered RAM with 1-cycle read latency.
data_bus  output  DATA_WIDTH  registered word to the serializer.
data_valid  output  1  data_bus carries a pattern word.
sync  output  1  serializer SYNC request.
busy  output  1  state != IDLE.
loaded_words  output  ADDR_WIDTH+1  number of words stored by the last completed load.

Behaviour:
Reset values (asynchronous, while reset_active_low=0):
- state=IDLE.
- All outputs 0, except data_bus=IDLE_WORD.
- loaded_words=0, all address counters 0.
- A reset asserted mid-LOAD or mid-PLAY discards everything, including loaded_words.

States: IDLE(0), LOAD(1), SYNC(2), PLAY(3), DRAIN(4).

IDLE:
- If load_start=1 -> LOAD, waddr=0.
- Else if play_start=1 and loaded_words!=0 -> SYNC; latch play_loop; sync counter=0.
- If load_start and play_start arrive together, load wins.
- play_start with loaded_words=0 is ignored.

LOAD:
- load_ready=1.
- Each cycle with load_valid=1: ram_we=1 combinationally, ram_waddr=waddr, ram_wdata=load_data; waddr increments on the next edge.
- The load ends on the accepted beat where load_last=1 or waddr=2**ADDR_WIDTH-1.
- On ending: loaded_words=waddr+1; next cycle load_done=1 for one cycle and state=IDLE.
- play_stop in LOAD -> IDLE next cycle; loaded_words=0; no load_done.

SYNC:
- sync=1 for exactly SYNC_CYCLES consecutive cycles, starting the cycle after play_start.
- data_bus=IDLE_WORD, data_valid=0, raddr=0.
- Then -> PLAY.
- play_stop in SYNC -> IDLE next cycle; sync drops.

PLAY:
- ram_raddr=raddr; raddr increments each cycle.
- data_bus<=ram_rdata and data_valid<=1 one cycle after each read address is presented.
- First pattern word appears on data_bus SYNC_CYCLES+2 cycles after play_start.
- At raddr=loaded_words-1:
  - If looped, raddr wraps to 0 with no gap (word 0 immediately follows the last word).
  - Otherwise -> DRAIN.
- play_stop -> DRAIN; the word already read is still output.

DRAIN:
- Outputs the final in-flight word with data_valid=1 for one cycle.
- Then IDLE, with data_bus=IDLE_WORD and data_valid=0.

General rules:
- load_start and play_start outside IDLE are ignored.
- play_stop in IDLE is ignored.
- Arithmetic: raddr and waddr are ADDR_WIDTH bits and wrap modulo 2**ADDR_WIDTH; loaded_words is ADDR_WIDTH+1 bits so it can represent a full RAM.
- Bench RAM model: registered read, write-first.

Test Plan:
1. Load, one-shot play: load 4 words 0x001,0x002,0x003,0x3FF with load_last on the 4th -> load_done pulse, loaded_words=4; play_start with play_loop=0 and SYNC_CYCLES=8 -> sync high 8 cycles; data_bus = 001,002,003,3FF on 4 consecutive cycles with data_valid=1; then IDLE_WORD and busy=0.
2. Full-depth load: load 2048 words with no load_last -> ends after word 2047, loaded_words=2048, load_done pulses once; the 2049th load_valid is not written.
3. Looped play: loop play of a 3-word pattern A,B,C -> data_bus shows A,B,C,A,B,C with no gap; play_stop while C is being read -> C output, then IDLE within 2 cycles.
4. Command priority and guards: load_start and play_start in the same IDLE cycle -> LOAD entered and sync stays 0. play_start with loaded_words=0 -> stays IDLE. play_start during LOAD -> ignored.
5. Stops: play_stop during SYNC -> sync drops next cycle, no data_valid. play_stop mid-LOAD -> loaded_words=0 and no load_done.
6. Reset mid-play: assert reset_active_low=0 mid-PLAY, asynchronously -> all outputs go to reset values before the next edge and loaded_words=0; after release, play_start is ignored until a new load.
